// File: rtl/count_enable_ctrl_pkg.sv
// Shared types and default widths for the counter run-control block.
package count_enable_ctrl_pkg;

    localparam int CEC_PRESCALE_W = 8;
    localparam int CEC_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } cec_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable tick divider: registered tick every prescale+1 cycles while run=1.
// hold freezes the count and suppresses the tick; run=0 returns the count to 0.
module tick_prescaler
    import count_enable_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = CEC_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  hold,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] ONE = 1;

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == prescale) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/count_enable_ctrl.sv
// Run-control for a downstream synchronous counter: clear, prescaled enable, one-shot stop.
// Optional COUNT_ENABLE_CTRL_PAUSE_EN adds a pause input that freezes the prescaler in RUN.
module count_enable_ctrl
    import count_enable_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = CEC_PRESCALE_W,
    parameter int CNT_W      = CEC_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
`ifdef COUNT_ENABLE_CTRL_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic                  oneshot,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CNT_W-1:0]      target,
    input  logic [CNT_W-1:0]      q_in,
    output logic                  enable,
    output logic                  cnt_clear,
    output logic                  busy,
    output logic                  done
);

    cec_state_t            state_q, state_d;
    logic                  oneshot_q, oneshot_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0]      target_q, target_d;
    logic                  cnt_clear_q, cnt_clear_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  run, hold, tick, hit;
    logic [CNT_W-1:0]      q_next;

`ifdef COUNT_ENABLE_CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Look one tick ahead so the enable that would overshoot is never issued.
    assign q_next = q_in + {{(CNT_W-1){1'b0}}, tick};
    assign hit    = oneshot_q && (q_next == target_q);

    always_comb begin
        state_d    = state_q;
        oneshot_d  = oneshot_q;
        prescale_d = prescale_q;
        target_d   = target_q;
        run        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = CLEAR;
                    oneshot_d  = oneshot;
                    prescale_d = prescale;
                    target_d   = target;
                end
            end
            CLEAR:   state_d = stop ? IDLE : RUN;
            RUN: begin
                if (stop)     state_d = IDLE;
                else if (hit) state_d = DONE;
                else          run     = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_clear_d = (state_d == CLEAR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            oneshot_q   <= 1'b0;
            prescale_q  <= '0;
            target_q    <= '0;
            cnt_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            oneshot_q   <= oneshot_d;
            prescale_q  <= prescale_d;
            target_q    <= target_d;
            cnt_clear_q <= cnt_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .hold     (hold),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign enable    = tick;
    assign cnt_clear = cnt_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Scoreboard bench: per-cycle {enable,cnt_clear,busy,done} expectations derived from the
// documented timing are queued, then popped and compared as the DUT runs with a counter model.
module tb_count_enable_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, pause, oneshot;
    logic [7:0] prescale;
    logic [3:0] target;
    logic [3:0] q_cnt = 4'd0;
    logic       enable, cnt_clear, busy, done;
    logic [3:0] obs;
    logic [3:0] exp_q[$];
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    count_enable_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
`ifdef COUNT_ENABLE_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .oneshot   (oneshot),
        .prescale  (prescale),
        .target    (target),
        .q_in      (q_cnt),
        .enable    (enable),
        .cnt_clear (cnt_clear),
        .busy      (busy),
        .done      (done)
    );

    // Downstream 4-bit counter; not reset by reset_n.
    always @(posedge clk) begin
        if (cnt_clear)   q_cnt <= 4'd0;
        else if (enable) q_cnt <= q_cnt + 4'd1;
    end

    assign obs = {enable, cnt_clear, busy, done};

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic [3:0] e;
        reset_n = 1'b0; step; step;
        reset_n = 1'b1;
        exp_q.push_back(4'b0000);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            errors++; $display("FAIL reset_state got %b exp %b", obs, e);
        end
        step;
        // one-shot p=2 t=3, reset held in cycles 6 and 7
        start = 1'b1; oneshot = 1'b1; prescale = 8'd2; target = 4'd3;
        step;
        start = 1'b0;
        repeat (5) step;
        reset_n = 1'b0; step; step;
        reset_n = 1'b1;
        repeat (4) exp_q.push_back(4'b0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_midrun cyc %0d got %b exp %b", c, obs, e);
            end
            step;
        end
        vectors++;
        if (q_cnt !== 4'd1) begin
            errors++; $display("FAIL reset_q_kept got %0d exp 1", q_cnt);
        end
    endtask

    task automatic test_oneshot(input string name, input int p, input int t,
                                input int pat, input int plen, input bit mid_start);
        int         ticks[$];
        int         dn, nc;
        logic [3:0] e;
        for (int i = 0; i < t; i++) begin
            int c;
            c = 3 + p + i * (p + 1);
            if (plen > 0 && c > pat) c += plen;
            ticks.push_back(c);
        end
        dn = (t == 0) ? 3 : ticks[t-1] + 1;
        nc = dn + 3;
        for (int c = 0; c < nc; c++) begin
            bit en;
            en = 1'b0;
            foreach (ticks[i]) if (ticks[i] == c) en = 1'b1;
            exp_q.push_back({en, (c == 1), (c >= 1 && c <= dn), (c == dn)});
        end
        for (int c = 0; c < nc; c++) begin
            start    = (c == 0) || (mid_start && c == 4);
            oneshot  = (c == 0);
            prescale = (c == 0) ? 8'(p) : 8'(p + 5);
            target   = (c == 0) ? 4'(t) : 4'(t + 7);
            pause    = (plen > 0 && c >= pat && c < pat + plen);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                errors++; $display("FAIL %s cyc %0d got %b exp %b", name, c, obs, e);
            end
            step;
        end
        start = 1'b0; pause = 1'b0;
        vectors++;
        if (q_cnt !== 4'(t)) begin
            errors++; $display("FAIL %s_final_q got %0d exp %0d", name, q_cnt, t);
        end
    endtask

    task automatic test_freerun;
        logic [3:0] e;
        for (int c = 0; c < 26; c++)
            exp_q.push_back({(c >= 3 && c <= 22), (c == 1), (c >= 1 && c <= 22), 1'b0});
        for (int c = 0; c < 26; c++) begin
            start    = (c == 0);
            oneshot  = 1'b0;
            prescale = (c == 0) ? 8'd0 : 8'd9;
            target   = 4'd5;
            stop     = (c == 22);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                errors++; $display("FAIL freerun cyc %0d got %b exp %b", c, obs, e);
            end
            step;
        end
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (q_cnt !== 4'd4) begin
            errors++; $display("FAIL freerun_wrap_q got %0d exp 4", q_cnt);
        end
    endtask

    task automatic test_start_stop;
        logic [3:0] e;
        // start+stop together in IDLE, then stop during CLEAR
        for (int c = 0; c < 4; c++) exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0110);
        for (int c = 0; c < 3; c++) exp_q.push_back(4'b0000);
        for (int c = 0; c < 9; c++) begin
            start    = (c == 0) || (c == 4);
            stop     = (c == 0) || (c == 5);
            oneshot  = 1'b1;
            prescale = 8'd0;
            target   = 4'd2;
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                errors++; $display("FAIL start_stop cyc %0d got %b exp %b", c, obs, e);
            end
            step;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        oneshot = 1'b0; prescale = 8'd0; target = 4'd0;
        step;
        test_reset;
        test_oneshot("oneshot_p2_t3", 2, 3, 0, 0, 1'b1);
        test_oneshot("oneshot_p0_t3", 0, 3, 0, 0, 1'b1);
        test_oneshot("oneshot_p0_t0", 0, 0, 0, 0, 1'b0);
        test_oneshot("back_to_back", 1, 15, 0, 0, 1'b1);
        test_freerun;
        test_start_stop;
`ifdef COUNT_ENABLE_CTRL_PAUSE_EN
        test_oneshot("pause_p3_t3", 3, 3, 7, 5, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
